// File: rtl/check_pkg.sv
// Shared types and constants for the serial feeder and the "10010" sequence checker.
package check_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    localparam int         DATA_W_DEF = 8;
    localparam logic [4:0] PATTERN    = 5'b10010;

endpackage

// File: rtl/hold_reg.sv
// One-entry holding register: decouples the upstream producer from the shifter.
module hold_reg #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load_i,
    input  logic         take_i,
    input  logic [W-1:0] data_i,
    output logic [W-1:0] data_o,
    output logic         full_o
);

    logic [W-1:0] data_q, data_d;
    logic         full_q, full_d;

    // load and take never coincide: load needs an empty slot, take a full one
    always_comb begin
        data_d = data_q;
        full_d = full_q;
        if (load_i) begin
            data_d = data_i;
            full_d = 1'b1;
        end else if (take_i) begin
            full_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q <= '0;
            full_q <= 1'b0;
        end else begin
            data_q <= data_d;
            full_q <= full_d;
        end
    end

    assign data_o = data_q;
    assign full_o = full_q;

endmodule

// File: rtl/serial_feeder.sv
// Parallel-to-serial front end: valid/ready words in, MSB-first bit stream out on num.
//   state | meaning
//   IDLE  | shifter empty, num driven with idle fill
//   SHIFT | shifter holds a word, bit_idx counts down to the LSB
module serial_feeder
    import check_pkg::*;
#(
    parameter int   DATA_W   = DATA_W_DEF,
    parameter logic IDLE_LVL = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              num,
    output logic              num_valid,
    output logic              busy,
    output logic [15:0]       words_sent
);

    localparam int                IDX_W   = $clog2(DATA_W);
    localparam logic [IDX_W-1:0]  IDX_TOP = IDX_W'(DATA_W - 1);

    state_t             state_q;
    logic [DATA_W-1:0]  shift_q;
    logic [IDX_W-1:0]   bit_idx_q;
    logic [15:0]        words_sent_q;

    logic               hold_full;
    logic [DATA_W-1:0]  hold_data;
    logic               transfer;
    logic               last_bit;
    logic               hold_load;
    logic               hold_take;

    assign in_ready  = !hold_full;
    assign transfer  = in_valid && in_ready;
    assign last_bit  = (state_q == SHIFT) && (bit_idx_q == '0);
    // On the last bit with an empty holding slot the new word goes straight into the shifter
    assign hold_load = transfer && (state_q == SHIFT) && !last_bit;
    assign hold_take = last_bit && hold_full;

    hold_reg #(.W(DATA_W)) u_hold (
        .clk    (clk),
        .rst    (rst),
        .load_i (hold_load),
        .take_i (hold_take),
        .data_i (in_data),
        .data_o (hold_data),
        .full_o (hold_full)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            shift_q      <= '0;
            bit_idx_q    <= '0;
            words_sent_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (transfer) begin
                        shift_q   <= in_data;
                        bit_idx_q <= IDX_TOP;
                        state_q   <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (bit_idx_q != '0) begin
                        shift_q   <= shift_q << 1;
                        bit_idx_q <= bit_idx_q - IDX_W'(1);
                    end else begin
                        words_sent_q <= words_sent_q + 16'd1;
                        if (hold_full) begin
                            shift_q   <= hold_data;
                            bit_idx_q <= IDX_TOP;
                        end else if (transfer) begin
                            shift_q   <= in_data;
                            bit_idx_q <= IDX_TOP;
                        end else begin
                            state_q <= IDLE;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign num        = (state_q == SHIFT) ? shift_q[DATA_W-1] : IDLE_LVL;
    assign num_valid  = (state_q == SHIFT);
    assign busy       = (state_q == SHIFT) || hold_full;
    assign words_sent = words_sent_q;

endmodule

// File: tb/tb_serial_feeder.sv
// Randomized self-checking bench for serial_feeder against a word-queue reference model.
module tb_serial_feeder;
    import check_pkg::*;

    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic [DW-1:0] in_data;
    logic          in_valid;
    logic          in_ready;
    logic          num;
    logic          num_valid;
    logic          busy;
    logic [15:0]   words_sent;

    int errors = 0;
    int checks = 0;

    // Reference: queue of accepted words; head is being shifted, m_bits bits already sent
    logic [DW-1:0] mq[$];
    int            m_bits;
    logic [15:0]   m_words;

    serial_feeder #(.DATA_W(DW), .IDLE_LVL(1'b0)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .num        (num),
        .num_valid  (num_valid),
        .busy       (busy),
        .words_sent (words_sent)
    );

    always #5 clk = ~clk;

    function automatic logic [19:0] exp_vec();
        logic [DW-1:0] w;
        logic          n;
        logic          occ;
        logic          rdy;
        n   = 1'b0;
        occ = (mq.size() > 0);
        rdy = (mq.size() < 2);
        if (occ) begin
            w = mq[0];
            n = w[DW-1-m_bits];
        end
        return {n, occ, occ, rdy, m_words};
    endfunction

    function automatic logic [19:0] obs_vec();
        return {num, num_valid, busy, in_ready, words_sent};
    endfunction

    task automatic model_reset();
        mq.delete();
        m_bits  = 0;
        m_words = '0;
    endtask

    // Drive one cycle from a negedge to the next, advancing the model at the posedge
    task automatic tick(input logic v, input logic [DW-1:0] d, output logic acc);
        in_valid = v;
        in_data  = d;
        acc      = v && (mq.size() < 2);
        @(posedge clk);
        if (mq.size() > 0) begin
            m_bits++;
            if (m_bits == DW) begin
                void'(mq.pop_front());
                m_bits  = 0;
                m_words = m_words + 16'd1;
            end
        end
        if (acc) mq.push_back(d);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst      = 1'b1;
        in_valid = 1'b0;
        in_data  = '0;
        model_reset();
        repeat (3) @(negedge clk);
        checks++;
        if ({num, num_valid, in_ready, busy, words_sent} !== {1'b0, 1'b0, 1'b1, 1'b0, 16'h0000}) begin
            errors++;
            $display("FAIL reset_values: got %h want %h", {num, num_valid, in_ready, busy, words_sent},
                     {1'b0, 1'b0, 1'b1, 1'b0, 16'h0000});
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (obs_vec() !== exp_vec()) begin
            errors++;
            $display("FAIL reset_release: got %h want %h", obs_vec(), exp_vec());
        end
    endtask

    task automatic test_single_word();
        logic        acc;
        logic [DW-1:0] bits;
        int          nv;
        logic [15:0] w0;
        w0   = m_words;
        bits = '0;
        nv   = 0;
        tick(1'b1, 8'h92, acc);
        for (int i = 0; i < 12; i++) begin
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL single_cycle%0d: got %h want %h", i, obs_vec(), exp_vec());
            end
            if (num_valid) begin
                bits = {bits[DW-2:0], num};
                nv++;
            end
            tick(1'b0, '0, acc);
        end
        checks++;
        if (bits !== 8'h92) begin
            errors++;
            $display("FAIL single_bits: got %h want %h", bits, 8'h92);
        end
        checks++;
        if (nv != 8) begin
            errors++;
            $display("FAIL single_valid_len: got %0d want 8", nv);
        end
        checks++;
        if (words_sent !== w0 + 16'd1) begin
            errors++;
            $display("FAIL single_words: got %0d want %0d", words_sent, w0 + 16'd1);
        end
    endtask

    task automatic test_back_to_back();
        logic [DW-1:0] wl[3];
        logic        acc;
        int          idx;
        int          nv;
        int          first_v;
        int          last_v;
        logic        saw_busy_block;
        logic [15:0] w0;
        wl = '{8'hA5, 8'h3C, 8'hFF};
        w0 = m_words;
        idx = 0; nv = 0; first_v = -1; last_v = -1; saw_busy_block = 1'b0;
        for (int c = 0; c < 40; c++) begin
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL b2b_cycle%0d: got %h want %h", c, obs_vec(), exp_vec());
            end
            if (num_valid) begin
                nv++;
                if (first_v < 0) first_v = c;
                last_v = c;
            end
            if (!in_ready) saw_busy_block = 1'b1;
            if (idx < 3) begin
                tick(1'b1, wl[idx], acc);
                if (acc) idx++;
            end else begin
                tick(1'b0, '0, acc);
            end
        end
        checks++;
        if (nv != 24 || (last_v - first_v + 1) != 24) begin
            errors++;
            $display("FAIL b2b_contiguous: got %0d valid over span %0d want 24", nv, last_v - first_v + 1);
        end
        checks++;
        if (saw_busy_block !== 1'b1) begin
            errors++;
            $display("FAIL b2b_ready_drop: got %b want 1", saw_busy_block);
        end
        checks++;
        if (words_sent !== w0 + 16'd3) begin
            errors++;
            $display("FAIL b2b_words: got %0d want %0d", words_sent, w0 + 16'd3);
        end
    endtask

    task automatic test_backpressure();
        logic [DW-1:0] wl[3];
        logic        acc;
        int          idx;
        int          stalled;
        logic [15:0] w0;
        for (int i = 0; i < 3; i++) wl[i] = DW'($urandom);
        w0 = m_words;
        idx = 0; stalled = 0;
        for (int c = 0; c < 36; c++) begin
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL bp_cycle%0d: got %h want %h", c, obs_vec(), exp_vec());
            end
            if (idx < 3) begin
                if (idx == 2 && !in_ready) stalled++;
                tick(1'b1, wl[idx], acc);
                if (acc) idx++;
            end else begin
                tick(1'b0, '0, acc);
            end
        end
        checks++;
        if (stalled != DW - 1) begin
            errors++;
            $display("FAIL bp_stall_len: got %0d want %0d", stalled, DW - 1);
        end
        checks++;
        if (words_sent !== w0 + 16'd3) begin
            errors++;
            $display("FAIL bp_words: got %0d want %0d", words_sent, w0 + 16'd3);
        end
    endtask

    task automatic test_random();
        logic acc;
        for (int c = 0; c < 420; c++) begin
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL rand_cycle%0d: got %h want %h", c, obs_vec(), exp_vec());
            end
            if (c < 400) tick(1'($urandom_range(0, 1)), DW'($urandom), acc);
            else         tick(1'b0, '0, acc);
        end
    endtask

    task automatic test_reset_mid_word();
        logic acc;
        tick(1'b1, 8'hF0, acc);
        tick(1'b1, DW'($urandom), acc);
        tick(1'b0, '0, acc);
        tick(1'b0, '0, acc);
        checks++;
        if (obs_vec() !== exp_vec()) begin
            errors++;
            $display("FAIL mid_before_rst: got %h want %h", obs_vec(), exp_vec());
        end
        rst = 1'b1;
        #1;
        model_reset();
        checks++;
        if ({num, num_valid, busy, in_ready, words_sent} !== {1'b0, 1'b0, 1'b0, 1'b1, 16'h0000}) begin
            errors++;
            $display("FAIL mid_async_rst: got %h want %h", {num, num_valid, busy, in_ready, words_sent},
                     {1'b0, 1'b0, 1'b0, 1'b1, 16'h0000});
        end
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 12; c++) begin
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL mid_after_rst%0d: got %h want %h", c, obs_vec(), exp_vec());
            end
            tick(1'b0, '0, acc);
        end
    endtask

    task automatic test_wrap();
        logic acc;
        int   idx;
        force dut.words_sent_q = 16'hFFFE;
        #1;
        release dut.words_sent_q;
        m_words = 16'hFFFE;
        @(negedge clk);
        checks++;
        if (words_sent !== 16'hFFFE) begin
            errors++;
            $display("FAIL wrap_preload: got %h want fffe", words_sent);
        end
        idx = 0;
        for (int c = 0; c < 24; c++) begin
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL wrap_cycle%0d: got %h want %h", c, obs_vec(), exp_vec());
            end
            if (idx < 2) begin
                tick(1'b1, DW'($urandom), acc);
                if (acc) idx++;
            end else begin
                tick(1'b0, '0, acc);
            end
        end
        checks++;
        if (words_sent !== 16'h0000) begin
            errors++;
            $display("FAIL wrap_zero: got %h want 0000", words_sent);
        end
    endtask

    initial begin
        rst      = 1'b1;
        in_valid = 1'b0;
        in_data  = '0;
        model_reset();
        test_reset();
        test_single_word();
        test_back_to_back();
        test_backpressure();
        test_random();
        test_reset_mid_word();
        test_wrap();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
